morra_match_driver: RTL and testbench
=====================================

Name: morra_match_driver

Overview:
- Player-side driver for the MorraCinese game FSMD.
- Generates the game inputs: the INIZIA pulse and the PRIMO/SECONDO move pairs, one pair per clock, from two seeded LFSRs. Moves obey the repeat-ban rule.
- Consumes the game outputs MANCHE/PARTITA, detects end of match and reports the result and per-match statistics.
- Sits opposite the game FSMD in self-play and regression systems. It replaces hand-written stimulus.

Parameters:
- MAX_CYCLES, 24, PLAY cycles allowed before a match is aborted with timeout.
- DEFAULT_SEED, 16'hACE1, LFSR value used whenever a seed would be zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a match; ignored unless in IDLE.
- seed  in  16  player-1 LFSR seed, sampled with start; player-2 seed is ~seed.
- inizia  out  1  game INIZIA; high for exactly one cycle per match.
- primo  out  2  game PRIMO move: 01 rock, 10 paper, 11 scissors, 00 none.
- secondo  out  2  game SECONDO move, same encoding.
- manche  in  2  game MANCHE: 00 invalid, 01 P1 wins round, 10 P2 wins round, 11 draw.
- partita  in  2  game PARTITA: 00 ongoing, 01 P1, 10 P2, 11 draw.
- busy  out  1  match in progress (INIT, PLAY or DRAIN).
- done  out  1  high from match end until the next start or rst.
- result  out  2  final PARTITA value; 00 on timeout.
- timeout  out  1  match aborted after MAX_CYCLES.
- rounds  out  5  valid rounds observed (manche != 00), saturating at 31.
- wins1, wins2, draws  out  5 each  statistics; see Optional Feature.

Behaviour:
- Reset values: all outputs 0, state IDLE, both LFSRs = DEFAULT_SEED, last-winner registers cleared.
- Move encoding 00 is never driven in PLAY.

FSM:
- IDLE: outputs idle. On start, load LFSR1=seed and LFSR2=~seed; any zero value is replaced by DEFAULT_SEED. Clear done, result, timeout and counters. Go to INIT.
- INIT: one cycle with inizia=1, primo=secondo=00. Go to PLAY.
- PLAY: drive a new pair every cycle and step both LFSRs one step per cycle.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting left.
  - Candidate move = LFSR[1:0], with 00 mapped to 01.
- DRAIN: one cycle driving 00/00, then go to DONE.
- DONE: done=1; hold result until start (go to INIT, same as from IDLE) or rst.

Result latency:
- The game output for the pair driven in cycle n is valid in cycle n+1 and sampled at the end of cycle n+1.
- The first PLAY cycle samples the game output produced by the INIZIA cycle; it is ignored for statistics and rule tracking.

Repeat-ban rule:
- If the sampled manche=01, the move primo drove in cycle n-1 becomes P1's forbidden move. manche=10 does the same for P2.
- Draw, invalid or a win by the other player clears that player's forbidden move.
- If a candidate equals the player's forbidden move, rotate it 01->10->11->01.
- This uses the current-cycle manche combinationally. The game outputs are registered, so no loop exists.

End of match:
- A sampled partita != 00 in PLAY latches result=partita and moves to DRAIN.
- The pair driven in that same cycle is consumed by the finished game and ignored; it is not counted.

Timeout:
- A PLAY cycle counter reaching MAX_CYCLES with partita=00 sets timeout=1, result=00 and moves to DRAIN.
- If partita != 00 in the same cycle, the match result wins and timeout stays 0.

Other rules:
- start while busy or while rst is high is ignored.
- rst mid-match returns to IDLE next edge. No inizia is issued; the next start re-initialises the game.
- Counters saturate at 31 and never wrap.

Optional Feature:
- Macro: MORRA_DRV_STATS_EN.
- Defined: wins1, wins2 and draws count sampled manche values 01, 10 and 11 respectively during PLAY (first sample excluded), saturating at 31.
- Not defined: wins1, wins2 and draws are tied to 0 and no counter registers exist.
- rounds, result and timeout behave the same either way.

Test Plan:
- rst held 2 cycles, then released -> all outputs 0, state IDLE, no inizia.
- start=1 with seed=16'h0000 -> next cycle inizia=1 with primo=secondo=00; following cycles primo is derived from LFSR1=16'hACE1 and secondo from LFSR2=16'hFFFF; primo and secondo never 00.
- Bench forces manche=01 while the previous primo was 10 -> primo in the same cycle is not 10 (rotates to 11 if the candidate was 10).
- Behavioural game model returns partita=01 after 5 valid rounds -> one 00/00 DRAIN cycle, then done=1, result=01, rounds=5, timeout=0; with MORRA_DRV_STATS_EN, wins1+wins2+draws=5.
- partita held at 00 -> after 24 PLAY cycles: timeout=1, result=00, done=1; a second start restarts cleanly with inizia=1.
- rst asserted in the 3rd PLAY cycle -> busy=0 and primo=secondo=00 next cycle; start pulsed during PLAY has no effect.

Source files
------------

// File: rtl/morra_match_driver_if.sv
// Signal bundle between the Morra match driver (master) and the game / system side (slave).
interface morra_match_driver_if;
    logic        start;
    logic [15:0] seed;
    logic        inizia;
    logic [1:0]  primo;
    logic [1:0]  secondo;
    logic [1:0]  manche;
    logic [1:0]  partita;
    logic        busy;
    logic        done;
    logic [1:0]  result;
    logic        timeout;
    logic [4:0]  rounds;
    logic [4:0]  wins1;
    logic [4:0]  wins2;
    logic [4:0]  draws;

    modport master (
        input  start, seed, manche, partita,
        output inizia, primo, secondo, busy, done, result, timeout, rounds, wins1, wins2, draws
    );

    modport slave (
        output start, seed, manche, partita,
        input  inizia, primo, secondo, busy, done, result, timeout, rounds, wins1, wins2, draws
    );
endinterface

// File: rtl/morra_match_driver.sv
// Player-side driver for the MorraCinese game: LFSR move pairs with the repeat-ban rule,
// end-of-match detection and statistics. Define MORRA_DRV_STATS_EN for win/draw counters.
module morra_match_driver #(
    parameter int unsigned MAX_CYCLES   = 24,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input logic                  clk,
    input logic                  rst,
    morra_match_driver_if.master bus
);
    localparam int unsigned CntW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StInit, StPlay, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [15:0]     lfsr1_q, lfsr1_d, lfsr2_q, lfsr2_d;
    logic [1:0]      last1_q, last1_d, last2_q, last2_d;
    logic [CntW-1:0] cyc_q, cyc_d;
    logic [1:0]      result_q, result_d;
    logic            timeout_q, timeout_d;
    logic [4:0]      rounds_q, rounds_d;
    logic            match_start, sample_ok;
    logic [1:0]      ban1, ban2, move1, move2;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] seed_fix(input logic [15:0] v);
        return (v == 16'h0000) ? DEFAULT_SEED : v;
    endfunction

    // Candidate 00 becomes rock; a forbidden candidate rotates 01->10->11->01.
    function automatic logic [1:0] pick(input logic [1:0] raw, input logic [1:0] ban);
        logic [1:0] c;
        c = (raw == 2'b00) ? 2'b01 : raw;
        if (c == ban) begin
            c = (c == 2'b11) ? 2'b01 : c + 2'b01;
        end
        return c;
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    assign match_start = (state_q == StIdle || state_q == StDone) && bus.start;
    // The first PLAY sample is the game's answer to INIZIA, not to a move pair.
    assign sample_ok   = (state_q == StPlay) && (cyc_q != '0);
    assign ban1        = (sample_ok && bus.manche == 2'b01) ? last1_q : 2'b00;
    assign ban2        = (sample_ok && bus.manche == 2'b10) ? last2_q : 2'b00;
    assign move1       = pick(lfsr1_q[1:0], ban1);
    assign move2       = pick(lfsr2_q[1:0], ban2);

    always_comb begin
        state_d     = state_q;
        lfsr1_d     = lfsr1_q;
        lfsr2_d     = lfsr2_q;
        last1_d     = last1_q;
        last2_d     = last2_q;
        cyc_d       = cyc_q;
        result_d    = result_q;
        timeout_d   = timeout_q;
        rounds_d    = rounds_q;
        bus.inizia  = 1'b0;
        bus.primo   = 2'b00;
        bus.secondo = 2'b00;
        unique case (state_q)
            StIdle, StDone: begin
                if (match_start) begin
                    state_d   = StInit;
                    lfsr1_d   = seed_fix(bus.seed);
                    lfsr2_d   = seed_fix(~bus.seed);
                    last1_d   = 2'b00;
                    last2_d   = 2'b00;
                    cyc_d     = '0;
                    result_d  = 2'b00;
                    timeout_d = 1'b0;
                    rounds_d  = 5'd0;
                end
            end
            StInit: begin
                bus.inizia = 1'b1;
                state_d    = StPlay;
            end
            StPlay: begin
                bus.primo   = move1;
                bus.secondo = move2;
                last1_d     = move1;
                last2_d     = move2;
                lfsr1_d     = lfsr_next(lfsr1_q);
                lfsr2_d     = lfsr_next(lfsr2_q);
                cyc_d       = cyc_q + 1'b1;
                if (sample_ok && bus.manche != 2'b00) begin
                    rounds_d = sat_inc(rounds_q);
                end
                // A finished game takes precedence over the cycle limit.
                if (bus.partita != 2'b00) begin
                    result_d = bus.partita;
                    state_d  = StDrain;
                end else if (cyc_q == CntW'(MAX_CYCLES - 1)) begin
                    result_d  = 2'b00;
                    timeout_d = 1'b1;
                    state_d   = StDrain;
                end
            end
            StDrain: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            lfsr1_q   <= DEFAULT_SEED;
            lfsr2_q   <= DEFAULT_SEED;
            last1_q   <= 2'b00;
            last2_q   <= 2'b00;
            cyc_q     <= '0;
            result_q  <= 2'b00;
            timeout_q <= 1'b0;
            rounds_q  <= 5'd0;
        end else begin
            state_q   <= state_d;
            lfsr1_q   <= lfsr1_d;
            lfsr2_q   <= lfsr2_d;
            last1_q   <= last1_d;
            last2_q   <= last2_d;
            cyc_q     <= cyc_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            rounds_q  <= rounds_d;
        end
    end

    assign bus.busy    = (state_q == StInit) || (state_q == StPlay) || (state_q == StDrain);
    assign bus.done    = (state_q == StDone);
    assign bus.result  = result_q;
    assign bus.timeout = timeout_q;
    assign bus.rounds  = rounds_q;

`ifdef MORRA_DRV_STATS_EN
    logic [4:0] wins1_q, wins1_d, wins2_q, wins2_d, draws_q, draws_d;

    always_comb begin
        wins1_d = wins1_q;
        wins2_d = wins2_q;
        draws_d = draws_q;
        if (match_start) begin
            wins1_d = 5'd0;
            wins2_d = 5'd0;
            draws_d = 5'd0;
        end else if (sample_ok) begin
            unique case (bus.manche)
                2'b01:   wins1_d = sat_inc(wins1_q);
                2'b10:   wins2_d = sat_inc(wins2_q);
                2'b11:   draws_d = sat_inc(draws_q);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wins1_q <= 5'd0;
            wins2_q <= 5'd0;
            draws_q <= 5'd0;
        end else begin
            wins1_q <= wins1_d;
            wins2_q <= wins2_d;
            draws_q <= draws_d;
        end
    end

    assign bus.wins1 = wins1_q;
    assign bus.wins2 = wins2_q;
    assign bus.draws = draws_q;
`else
    assign bus.wins1 = 5'd0;
    assign bus.wins2 = 5'd0;
    assign bus.draws = 5'd0;
`endif
endmodule

// File: tb/tb_morra_match_driver.sv
// Scoreboard bench for morra_match_driver: a behavioural game answers the driver, a reference
// move model checks every pair, and per-match results are checked when done rises.
module tb_morra_match_driver;
    localparam int unsigned MaxCycles = 24;

    typedef struct {
        logic [1:0] result;
        logic       timeout;
        logic [4:0] rounds;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    morra_match_driver_if bus ();

    morra_match_driver #(
        .MAX_CYCLES  (MaxCycles),
        .DEFAULT_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] s);
        if (p == s) return 2'b11;
        if ((p == 2'b01 && s == 2'b11) || (p == 2'b10 && s == 2'b01) ||
            (p == 2'b11 && s == 2'b10)) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [1:0] ref_move(input logic [15:0] l, input logic [1:0] ban);
        logic [1:0] m;
        m = l[1:0];
        if (m == 2'b00) m = 2'b01;
        if (m == ban) begin
            case (m)
                2'b01:   m = 2'b10;
                2'b10:   m = 2'b11;
                default: m = 2'b01;
            endcase
        end
        return m;
    endfunction

    // Behavioural game: registered MANCHE/PARTITA answering the pair seen in the previous cycle.
    logic [1:0]  g_man, g_par, g_end, s_p, s_s;
    logic        g_force, s_ini;
    int          g_cnt, g_target;
    logic [15:0] cur_seed;

    assign bus.manche  = g_man;
    assign bus.partita = g_par;

    always @(negedge clk) begin
        s_p   = bus.primo;
        s_s   = bus.secondo;
        s_ini = bus.inizia;
    end

    always @(posedge clk) begin
        if (rst || s_ini) begin
            g_man <= 2'b00;
            g_par <= 2'b00;
            g_cnt <= 0;
        end else if (s_p != 2'b00 && s_s != 2'b00 && g_par == 2'b00) begin
            g_man <= g_force ? 2'b01 : judge(s_p, s_s);
            g_cnt <= g_cnt + 1;
            if (g_target != 0 && g_cnt + 1 == g_target) g_par <= g_end;
        end else begin
            g_man <= 2'b00;
        end
    end

    // Monitor: reference move model plus match-result scoreboard.
    localparam int MIdle = 0, MPlay = 1, MDrain = 2, MPost = 3;
    int          m_phase, m_idx, m_w1, m_w2, m_dr;
    logic [15:0] m_l1, m_l2;
    logic [1:0]  m_p1, m_p2, f1, f2, e1, e2, dp, ds;
    logic        done_prev;

    always @(negedge clk) begin
        if (rst) begin
            m_phase   = MIdle;
            done_prev = 1'b0;
        end else begin
            if (bus.done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: got done=1, expected no pending match");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", 32'(bus.result), 32'(mon_e.result));
                    check("timeout", 32'(bus.timeout), 32'(mon_e.timeout));
                    check("rounds", 32'(bus.rounds), 32'(mon_e.rounds));
`ifdef MORRA_DRV_STATS_EN
                    check("wins1", 32'(bus.wins1), 32'(m_w1));
                    check("wins2", 32'(bus.wins2), 32'(m_w2));
                    check("draws", 32'(bus.draws), 32'(m_dr));
                    check("stats_sum", 32'(bus.wins1) + 32'(bus.wins2) + 32'(bus.draws),
                          32'(mon_e.rounds));
`else
                    check("stats_off", {17'd0, bus.wins1, bus.wins2, bus.draws}, 32'd0);
`endif
                end
            end
            done_prev = bus.done;
            case (m_phase)
                MIdle: begin
                    if (bus.inizia) begin
                        check("init_moves", {28'd0, bus.primo, bus.secondo}, 32'd0);
                        check("init_busy", 32'(bus.busy), 32'd1);
                        m_l1    = (cur_seed == 16'h0000) ? 16'hACE1 : cur_seed;
                        m_l2    = (cur_seed == 16'hFFFF) ? 16'hACE1 : ~cur_seed;
                        m_idx   = 0;
                        m_w1    = 0;
                        m_w2    = 0;
                        m_dr    = 0;
                        m_phase = MPlay;
                    end
                end
                MPlay: begin
                    f1 = (m_idx != 0 && bus.manche == 2'b01) ? m_p1 : 2'b00;
                    f2 = (m_idx != 0 && bus.manche == 2'b10) ? m_p2 : 2'b00;
                    e1 = ref_move(m_l1, f1);
                    e2 = ref_move(m_l2, f2);
                    check("primo", 32'(bus.primo), 32'(e1));
                    check("secondo", 32'(bus.secondo), 32'(e2));
                    if (f1 != 2'b00) check("p1_ban", 32'(bus.primo == f1), 32'd0);
                    if (cur_seed == 16'h0000 && m_idx < 3) begin
                        case (m_idx)
                            0:       {dp, ds} = {2'b01, 2'b11};
                            1:       {dp, ds} = {2'b11, 2'b10};
                            default: {dp, ds} = {2'b01, 2'b01};
                        endcase
                        check("seed0_pair", {28'd0, bus.primo, bus.secondo}, {28'd0, dp, ds});
                    end
                    if (cur_seed == 16'hFFFF && m_idx == 0)
                        check("seedffff_pair", {28'd0, bus.primo, bus.secondo}, 32'h0000_000D);
                    if (m_idx != 0) begin
                        if (bus.manche == 2'b01) m_w1++;
                        if (bus.manche == 2'b10) m_w2++;
                        if (bus.manche == 2'b11) m_dr++;
                    end
                    m_p1 = e1;
                    m_p2 = e2;
                    m_l1 = ref_step(m_l1);
                    m_l2 = ref_step(m_l2);
                    m_idx++;
                    if (bus.partita != 2'b00 || m_idx == MaxCycles) m_phase = MDrain;
                end
                MDrain: begin
                    check("drain_moves", {28'd0, bus.primo, bus.secondo}, 32'd0);
                    check("drain_busy", {30'd0, bus.busy, bus.done}, 32'd2);
                    m_phase = MPost;
                end
                default: begin
                    check("post_done", {30'd0, bus.busy, bus.done}, 32'd1);
                    m_phase = MIdle;
                end
            endcase
        end
    end

    task automatic run_match(input logic [15:0] s, input int tgt, input logic [1:0] endv,
                             input logic frc, input logic [1:0] eres, input logic eto,
                             input logic [4:0] ernd);
        exp_t e;
        int   waited;
        g_target  = tgt;
        g_end     = endv;
        g_force   = frc;
        cur_seed  = s;
        e.result  = eres;
        e.timeout = eto;
        e.rounds  = ernd;
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.seed = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.seed = ~s;
        for (waited = 0; waited < 60 && !bus.done; waited++) @(negedge clk);
        check("done_wait", 32'(bus.done), 32'd1);
        if (!bus.done) void'(exp_q.pop_back());
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.seed  = 16'h0000;
        g_target  = 0;
        g_end     = 2'b00;
        g_force   = 1'b0;
        cur_seed  = 16'h0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ctrl", {29'd0, bus.busy, bus.done, bus.inizia}, 32'd0);
        check("rst_moves", {28'd0, bus.primo, bus.secondo}, 32'd0);
        check("rst_result", {29'd0, bus.result, bus.timeout}, 32'd0);
        check("rst_counts", {12'd0, bus.rounds, bus.wins1, bus.wins2, bus.draws}, 32'd0);
        @(negedge clk);
        check("idle_no_inizia", 32'(bus.inizia), 32'd0);

        run_match(16'h0000, 5, 2'b01, 1'b0, 2'b01, 1'b0, 5'd5);
        run_match(16'h1234, 0, 2'b00, 1'b0, 2'b00, 1'b1, 5'd23);
        run_match(16'h00FF, 0, 2'b00, 1'b1, 2'b00, 1'b1, 5'd23);
        run_match(16'hFFFF, 3, 2'b11, 1'b0, 2'b11, 1'b0, 5'd3);
        run_match(16'hBEEF, 23, 2'b10, 1'b0, 2'b10, 1'b0, 5'd23);

        // Reset in the third PLAY cycle; start pulses during PLAY and during rst are ignored.
        g_target = 0;
        g_force  = 1'b0;
        cur_seed = 16'h5555;
        @(posedge clk);
        #1 bus.seed = 16'h5555;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("play_start_ignored", {30'd0, bus.busy, bus.inizia}, 32'd2);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_moves", {28'd0, bus.primo, bus.secondo}, 32'd0);
        @(negedge clk);
        check("rst_start_ignored", {30'd0, bus.busy, bus.inizia}, 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
